// File: rtl/palette_pkg.sv
// palette_pkg: shared types, FSM states and the power-on palette for palette_lut.
package palette_pkg;
  localparam int MAX_CH_W = 12;
  localparam logic [23:0] DEF8 [8] = '{24'h000000, 24'hDB203E, 24'h4D191B, 24'hA8B043,
                                      24'h2B3314, 24'hFFA900, 24'h472812, 24'hFFFFFF};
  typedef struct packed {
    logic [MAX_CH_W-1:0] r;
    logic [MAX_CH_W-1:0] g;
    logic [MAX_CH_W-1:0] b;
  } rgb_t;
  typedef enum logic {IDLE, RESTORE} pal_state_t;
  function automatic logic [MAX_CH_W-1:0] scale_ch(input logic [7:0] v, input int ch_w);
    return ch_w >= 8 ? MAX_CH_W'(v) << (ch_w - 8) : MAX_CH_W'(v >> (8 - ch_w));
  endfunction
  // Result occupies the low ch_w bits of each field.
  function automatic rgb_t default_rgb(input int idx, input int ch_w);
    logic [23:0] v;
    v = idx < 8 ? DEF8[idx[2:0]] : 24'h7F7F7F;
    return '{r: scale_ch(v[23:16], ch_w), g: scale_ch(v[15:8], ch_w), b: scale_ch(v[7:0], ch_w)};
  endfunction
endpackage

// File: rtl/palette_blink_timer.sv
// palette_blink_timer: frame counter driving the blink phase; exists only with PALETTE_BLINK_EN.
`ifdef PALETTE_BLINK_EN
module palette_blink_timer #(
  parameter int FRAMES = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_start_i,
  output logic phase_o
);
  localparam int CW = $clog2(FRAMES + 1);
  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          wrap;
  assign wrap = cnt_q == CW'(FRAMES - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (frame_start_i) begin
      cnt_q   <= wrap ? '0 : cnt_q + 1'b1;
      phase_q <= wrap ? ~phase_q : phase_q;
    end
  assign phase_o = phase_q;
endmodule
`endif

// File: rtl/palette_lut.sv
// palette_lut: programmable index->RGB palette, 2-cycle lookup, restore-to-defaults FSM.
// Defining PALETTE_BLINK_EN adds a per-entry blink attribute and the wr_blink/frame_start ports.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W        = 4,
  parameter int CH_W         = 8,
  parameter int BLINK_FRAMES = 32
) (
  input  logic              pixclk,
  input  logic              rst,
  input  logic              draw_area,
  input  logic [IDX_W-1:0]  pix_idx,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [3*CH_W-1:0] wr_rgb,
  input  logic              restore,
`ifdef PALETTE_BLINK_EN
  input  logic              wr_blink,
  input  logic              frame_start,
`endif
  output logic              busy,
  output logic [CH_W-1:0]   red,
  output logic [CH_W-1:0]   green,
  output logic [CH_W-1:0]   blue,
  output logic              de_out
);
  localparam int DEPTH = 2 ** IDX_W;
  if (IDX_W < 3 || IDX_W > 8 || CH_W < 4 || CH_W > 12 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("palette_lut: parameter out of range");
  end
  function automatic logic [3*CH_W-1:0] def_entry(input int i);
    rgb_t d;
    d = default_rgb(i, CH_W);
    return {d.r[CH_W-1:0], d.g[CH_W-1:0], d.b[CH_W-1:0]};
  endfunction
  pal_state_t        state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [3*CH_W-1:0] tbl_q [DEPTH];
  logic              de1_q, de2_q, show;
  logic [3*CH_W-1:0] ent1_q, rgb_q;
  logic              wr_ok;
  assign busy  = state_q == RESTORE;
  assign wr_ok = wr_en && !busy;
  always_ff @(posedge pixclk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (restore) begin
      state_q <= RESTORE;
      cnt_q   <= '0;
    end else if (state_q == RESTORE) begin
      state_q <= cnt_q == IDX_W'(DEPTH - 1) ? IDLE : RESTORE;
      cnt_q   <= cnt_q + 1'b1;
    end
  always_ff @(posedge pixclk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) tbl_q[i] <= def_entry(i);
    else if (busy) tbl_q[cnt_q] <= def_entry(int'(cnt_q));
    else if (wr_ok) tbl_q[wr_idx] <= wr_rgb;
`ifdef PALETTE_BLINK_EN
  logic [DEPTH-1:0] blink_q;
  logic             blk1_q, phase;
  always_ff @(posedge pixclk or posedge rst)
    if (rst) begin
      blink_q <= '0;
      blk1_q  <= 1'b0;
    end else begin
      blk1_q <= blink_q[pix_idx];
      if (busy) blink_q[cnt_q] <= 1'b0;
      else if (wr_ok) blink_q[wr_idx] <= wr_blink;
    end
  palette_blink_timer #(.FRAMES(BLINK_FRAMES)) u_blink (
    .clk_i        (pixclk),
    .rst_i        (rst),
    .frame_start_i(frame_start),
    .phase_o      (phase)
  );
  assign show = de1_q && !(blk1_q && !phase);
`else
  assign show = de1_q;
`endif
  // Stage 1 captures the entry as it stood before any same-edge write, so such a lookup sees the old value.
  always_ff @(posedge pixclk or posedge rst)
    if (rst) begin
      de1_q  <= 1'b0;
      ent1_q <= '0;
      de2_q  <= 1'b0;
      rgb_q  <= '0;
    end else begin
      de1_q  <= draw_area;
      ent1_q <= tbl_q[pix_idx];
      de2_q  <= de1_q;
      rgb_q  <= show ? ent1_q : '0;
    end
  assign {red, green, blue} = rgb_q;
  assign de_out = de2_q;
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: randomized and directed scoreboard bench for palette_lut (IDX_W=4, CH_W=8).
module tb_palette_lut;
`ifdef PALETTE_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif
  typedef struct packed {
    int          due;
    logic        de;
    logic [23:0] rgb;
  } exp_t;
  logic        pixclk = 1'b0, rst = 1'b1, draw_area = 1'b0, wr_en = 1'b0, restore = 1'b0;
  logic [3:0]  pix_idx = '0, wr_idx = '0;
  logic [23:0] wr_rgb = '0;
  logic        busy, de_out;
  logic [7:0]  red, green, blue;
`ifdef PALETTE_BLINK_EN
  logic        wr_blink = 1'b0, frame_start = 1'b0;
`endif
  logic [23:0] ref_tbl [16];
  bit          ref_blk [16];
  int          pending [$];
  int          pulses;
  exp_t        expq [$];
  int          cyc = 0, total = 0, bad = 0;
  always #5 pixclk = ~pixclk;
  palette_lut #(.IDX_W(4), .CH_W(8), .BLINK_FRAMES(2)) dut (
    .pixclk     (pixclk),
    .rst        (rst),
    .draw_area  (draw_area),
    .pix_idx    (pix_idx),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_rgb     (wr_rgb),
    .restore    (restore),
`ifdef PALETTE_BLINK_EN
    .wr_blink   (wr_blink),
    .frame_start(frame_start),
`endif
    .busy       (busy),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .de_out     (de_out)
  );
  function automatic logic [23:0] dflt(input int i);
    case (i)
      0: return {8'd0, 8'd0, 8'd0};
      1: return {8'd219, 8'd32, 8'd62};
      2: return {8'd77, 8'd25, 8'd27};
      3: return {8'd168, 8'd176, 8'd67};
      4: return {8'd43, 8'd51, 8'd20};
      5: return {8'd255, 8'd169, 8'd0};
      6: return {8'd71, 8'd40, 8'd18};
      7: return {8'd255, 8'd255, 8'd255};
      default: return {8'd127, 8'd127, 8'd127};
    endcase
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ref_tbl[i] = dflt(i);
      ref_blk[i] = 1'b0;
    end
    pending = {};
    pulses = 0;
    expq = {};
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // One pixel cycle: check busy, drive inputs, queue the expected output, advance the reference table.
  task automatic step(input bit d, input int idx, input bit we, input int widx, input logic [23:0] wv,
                      input bit rs, input bit wb, input bit fs, output bit b);
    bit show;
    @(negedge pixclk);
    b = busy;
    chk("busy", 32'(busy), 32'(pending.size() > 0));
    draw_area = d;
    pix_idx = 4'(idx);
    wr_en = we;
    wr_idx = 4'(widx);
    wr_rgb = wv;
    restore = rs;
`ifdef PALETTE_BLINK_EN
    wr_blink = wb;
    frame_start = fs;
`endif
    if (fs) pulses++;
    show = d && !(BLINK_ON && ref_blk[idx] && (pulses / 2) % 2 == 1);
    expq.push_back('{due: cyc + 2, de: d, rgb: show ? ref_tbl[idx] : 24'h0});
    if (pending.size() > 0) begin
      ref_tbl[pending[0]] = dflt(pending[0]);
      ref_blk[pending[0]] = 1'b0;
      void'(pending.pop_front());
    end else if (we) begin
      ref_tbl[widx] = wv;
      ref_blk[widx] = wb;
    end
    if (rs) begin
      pending = {};
      for (int i = 0; i < 16; i++) pending.push_back(i);
    end
  endtask
  task automatic look(input bit d, input int idx);
    bit b;
    step(d, idx, 1'b0, 0, 24'h0, 1'b0, 1'b0, 1'b0, b);
  endtask
  always @(posedge pixclk) begin
    cyc++;
    #1;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      exp_t e;
      e = expq.pop_front();
      total++;
      if ({de_out, red, green, blue} !== {e.de, e.rgb}) begin
        bad++;
        $display("FAIL lookup@%0d: got de=%0d rgb=%0d,%0d,%0d expected de=%0d rgb=%0d,%0d,%0d",
                 cyc, de_out, red, green, blue, e.de, e.rgb[23:16], e.rgb[15:8], e.rgb[7:0]);
      end
    end
  end
  initial begin
    bit b;
    int nb;
    model_reset();
    repeat (2) @(negedge pixclk);
    rst = 1'b0;
    chk("reset_rgb", 32'({red, green, blue}), 32'h0);
    chk("reset_de", 32'(de_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 16; i++) look(1'b1, i);
    look(1'b0, 7);
    step(1'b1, 3, 1'b1, 3, {8'd10, 8'd20, 8'd30}, 1'b0, 1'b0, 1'b0, b);
    look(1'b1, 3);
    look(1'b1, 3);
    step(1'b1, 2, 1'b0, 0, 24'h0, 1'b1, 1'b0, 1'b0, b);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i % 16, i == 3, 5, 24'hABCDEF, 1'b0, 1'b0, 1'b0, b);
      nb += int'(b);
    end
    chk("restore_busy_cycles", 32'(nb), 32'd16);
    look(1'b1, 3);
    look(1'b1, 5);
    step(1'b1, 0, 1'b0, 0, 24'h0, 1'b1, 1'b0, 1'b0, b);
    for (int i = 1; i <= 5; i++) step(1'b1, i, 1'b0, 0, 24'h0, i == 5, 1'b0, 1'b0, b);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i % 16, 1'b0, 0, 24'h0, 1'b0, 1'b0, 1'b0, b);
      nb += int'(b);
    end
    chk("repulse_busy_cycles", 32'(nb), 32'd16);
    step(1'b1, 4, 1'b1, 9, 24'h123456, 1'b0, 1'b0, 1'b0, b);
    step(1'b1, 9, 1'b0, 0, 24'h0, 1'b1, 1'b0, 1'b0, b);
    for (int i = 0; i < 4; i++) look(1'b1, 9);
    rst = 1'b1;
    expq = {};
    #1;
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_rgb", 32'({de_out, red, green, blue}), 32'h0);
    repeat (2) @(negedge pixclk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 16; i++) look(1'b1, i);
`ifdef PALETTE_BLINK_EN
    step(1'b1, 1, 1'b1, 1, 24'h112233, 1'b0, 1'b1, 1'b0, b);
    look(1'b1, 1);
    for (int p = 1; p <= 4; p++) begin
      step(1'b1, 1, 1'b0, 0, 24'h0, 1'b0, 1'b0, 1'b1, b);
      look(1'b1, 1);
    end
`endif
    for (int n = 0; n < 500; n++)
      step($urandom_range(3) != 0, int'($urandom_range(15)), $urandom_range(3) == 0,
           int'($urandom_range(15)), 24'($urandom), $urandom_range(59) == 0,
           1'($urandom_range(1)), $urandom_range(9) == 0, b);
    for (int i = 0; i < 4; i++) look(1'b0, 0);
    repeat (3) @(posedge pixclk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
